// File: rtl/sr_debug_pkg.sv
// Shared types and constants for the schoolRISCV debug controller.
package sr_debug_pkg;

  typedef enum logic [2:0] {
    OP_HALT   = 3'd0,
    OP_RUN    = 3'd1,
    OP_STEP   = 3'd2,
    OP_READ   = 3'd3,
    OP_SET_BP = 3'd4,
    OP_CLR_BP = 3'd5
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_HALTED    = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_STEPPING  = 2'd2,
    ST_READ_WAIT = 2'd3
  } dbg_state_t;

  localparam logic [31:0] DBG_REJECT = 32'hFFFF_FFFF;
  localparam logic [31:0] DBG_ACK    = 32'h0000_0000;

endpackage

// File: rtl/sr_debug_ctrl.sv
// Run/halt/single-step controller for the schoolRISCV core: gates execution via
// cpu_en, serves debug commands over valid/ready with a one-entry response register.
module sr_debug_ctrl
  import sr_debug_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_arg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             cpu_en,
  input  logic [31:0]      cpu_pc,
  output logic [4:0]       dbg_reg_addr,
  input  logic [31:0]      dbg_reg_data,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  dbg_state_t        state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_pc_q, rsp_pc_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [4:0]        dbg_reg_addr_q, dbg_reg_addr_d;
  logic [STEP_W-1:0] remaining_q, remaining_d;
  logic              first_q, first_d;
  logic              bp_en_q, bp_en_d;
  logic [31:0]       bp_addr_q, bp_addr_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;

  logic              accept_s;
  logic              bp_hit_s;
  logic              step_done_s;
  logic              is_halted_s;
  logic [STEP_W-1:0] step_n_s;

  assign accept_s    = cmd_valid & cmd_ready;
  assign bp_hit_s    = bp_en_q & (cpu_pc == bp_addr_q) & ~first_q;
  assign step_done_s = (state_q == ST_STEPPING) & (bp_hit_s | (remaining_q == STEP_W'(1)));
  assign is_halted_s = (state_q == ST_HALTED);
  assign step_n_s    = cmd_arg[STEP_W-1:0];

  // A deferred STEP response reports the live PC, which is frozen while halted.
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_pc_q ? cpu_pc : rsp_data_q;
  assign dbg_reg_addr = dbg_reg_addr_q;
  assign instr_count  = instr_count_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: begin
        if (accept_s && (cmd_op == OP_RUN)) begin
          state_d = ST_RUNNING;
        end else if (accept_s && (cmd_op == OP_STEP) && (step_n_s != '0)) begin
          state_d = ST_STEPPING;
        end else if (accept_s && (cmd_op == OP_READ)) begin
          state_d = ST_READ_WAIT;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        if (bp_hit_s || (accept_s && (cmd_op == OP_HALT))) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_STEPPING: state_d = step_done_s ? ST_HALTED : ST_STEPPING;
      ST_READ_WAIT: state_d = ST_HALTED;
      default: state_d = ST_HALTED;
    endcase
  end

  // FSM outputs: execution enable, command readiness, halted flag.
  always_comb begin
    cpu_en    = 1'b0;
    cmd_ready = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_HALTED: begin
        cmd_ready = ~rsp_valid_q;
        halted    = 1'b1;
      end
      ST_RUNNING: begin
        cmd_ready = ~rsp_valid_q;
        cpu_en    = ~bp_hit_s;
      end
      ST_STEPPING: cpu_en = ~bp_hit_s;
      default: cpu_en = 1'b0;
    endcase
  end

  // Datapath next-state: response register, step counter, breakpoint, counter.
  always_comb begin
    rsp_valid_d    = rsp_valid_q & ~rsp_ready;
    rsp_pc_d       = rsp_pc_q & ~rsp_ready;
    rsp_data_d     = (rsp_valid_q & rsp_ready & rsp_pc_q) ? cpu_pc : rsp_data_q;
    dbg_reg_addr_d = dbg_reg_addr_q;
    remaining_d    = (cpu_en && (state_q == ST_STEPPING)) ? (remaining_q - STEP_W'(1)) : remaining_q;
    first_d        = first_q & ~cpu_en;
    bp_en_d        = bp_en_q;
    bp_addr_d      = bp_addr_q;
    instr_count_d  = instr_count_q + (cpu_en ? CNT_W'(1) : CNT_W'(0));
    if (state_q == ST_READ_WAIT) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = 1'b0;
      rsp_data_d  = dbg_reg_data;
    end else if (step_done_s) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = 1'b1;
    end else if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_pc_d    = 1'b0;
      rsp_data_d  = DBG_ACK;
      case (cmd_op)
        OP_HALT: rsp_data_d = DBG_ACK;
        OP_RUN: begin
          if (is_halted_s) begin
            first_d = 1'b1;
          end else begin
            rsp_data_d = DBG_REJECT;
          end
        end
        OP_STEP: begin
          if (!is_halted_s) begin
            rsp_data_d = DBG_REJECT;
          end else if (step_n_s == '0) begin
            rsp_data_d = cpu_pc;
          end else begin
            rsp_valid_d = 1'b0;
            remaining_d = step_n_s;
            first_d     = 1'b1;
          end
        end
        OP_READ: begin
          if (is_halted_s) begin
            rsp_valid_d    = 1'b0;
            dbg_reg_addr_d = cmd_arg[4:0];
          end else begin
            rsp_data_d = DBG_REJECT;
          end
        end
        OP_SET_BP: begin
          bp_addr_d = cmd_arg;
          bp_en_d   = 1'b1;
        end
        OP_CLR_BP: bp_en_d = 1'b0;
        default: rsp_data_d = DBG_REJECT;
      endcase
    end else begin
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_pc_q       <= 1'b0;
      rsp_data_q     <= 32'h0000_0000;
      dbg_reg_addr_q <= 5'd0;
      remaining_q    <= '0;
      first_q        <= 1'b0;
      bp_en_q        <= 1'b0;
      bp_addr_q      <= 32'h0000_0000;
      instr_count_q  <= '0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_pc_q       <= rsp_pc_d;
      rsp_data_q     <= rsp_data_d;
      dbg_reg_addr_q <= dbg_reg_addr_d;
      remaining_q    <= remaining_d;
      first_q        <= first_d;
      bp_en_q        <= bp_en_d;
      bp_addr_q      <= bp_addr_d;
      instr_count_q  <= instr_count_d;
    end
  end

endmodule

// File: doc/sr_debug_ctrl.md
# sr_debug_ctrl

Run/halt/single-step controller for the schoolRISCV single-cycle CPU. It gates instruction execution through a per-cycle enable that drives the PC register and the register-file write enable. It takes debug commands over a valid/ready interface, supports one PC breakpoint, and reads architectural registers through the CPU's debug register port. It sits between the testbench/debug host and `sr_cpu`.

## Interface
- `STEP_W`, 16: width of the STEP count argument.
- `CNT_W`, 32: width of the executed-instruction counter.
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-low.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 3: opcode. 0 HALT, 1 RUN, 2 STEP, 3 READ, 4 SET_BP, 5 CLR_BP, 6–7 illegal.
- `cmd_arg` in 32: argument. STEP count in [STEP_W-1:0]; READ register address in [4:0]; SET_BP byte address.
- `rsp_valid` out 1: response valid. Held until `rsp_ready`.
- `rsp_ready` in 1: response accept.
- `rsp_data` out 32: response payload.
- `cpu_en` out 1: the CPU executes (PC update, register write) in this cycle.
- `cpu_pc` in 32: current CPU PC.
- `dbg_reg_addr` out 5: drives the CPU `regAddr`.
- `dbg_reg_data` in 32: CPU `regData`. Combinational; address 0 returns PC.
- `halted` out 1: state is HALTED.
- `instr_count` out CNT_W: number of cycles with `cpu_en`=1.

## Operation
- States: HALTED, RUNNING, STEPPING, READ_WAIT.
- Reset values: state HALTED, `halted`=1, `cpu_en`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `dbg_reg_addr`=0, `instr_count`=0, breakpoint disabled, `bp_addr`=0, `first`=0.
- `cmd_ready` = !`rsp_valid` and state ∈ {HALTED, RUNNING}.
- Every accepted command produces exactly one response. Accepted non-data commands respond 0x0000_0000. Rejected or illegal commands respond 0xFFFF_FFFF (REJECT).
- HALT:
  - From HALTED: no-op.
  - From RUNNING: go to HALTED.
- RUN:
  - From HALTED: go to RUNNING and set `first`=1.
  - From RUNNING: REJECT.
- STEP n:
  - From HALTED with n=0: immediate response of `cpu_pc`; stay HALTED.
  - From HALTED with n>0: load `remaining`=n, set `first`=1, go to STEPPING.
  - The response is deferred until stepping ends; its data is `cpu_pc` sampled in the first HALTED cycle.
  - From RUNNING: REJECT.
- READ a:
  - From HALTED: register `dbg_reg_addr`=a, go to READ_WAIT. Next cycle, capture `dbg_reg_data` into `rsp_data`, assert `rsp_valid`, return to HALTED.
  - From RUNNING: REJECT.
- SET_BP sets `bp_addr`=`cmd_arg` and `bp_en`=1. CLR_BP sets `bp_en`=0. Both are accepted in HALTED or RUNNING.
- Breakpoint hit: `bp_en` & (`cpu_pc`==`bp_addr`) & !`first`.
- `cpu_en` (combinational):
  - RUNNING: 1 unless breakpoint hit.
  - STEPPING: 1 unless breakpoint hit.
  - Otherwise: 0.
- `first` clears after the first `cpu_en` cycle. This lets the CPU resume from a breakpoint address.
- A breakpoint hit in RUNNING goes to HALTED with no response.
- STEPPING:
  - Each `cpu_en` cycle decrements `remaining`.
  - When `remaining` reaches 0, or on a breakpoint hit, go to HALTED and issue the deferred STEP response.
  - HALT cannot abort a STEP, because `cmd_ready`=0 in STEPPING.
- `instr_count` increments on every `cpu_en`=1 cycle and wraps modulo 2^CNT_W.

## Timing
- A command accepted at edge t changes state at t. Its response becomes visible in cycle t+1, except READ (t+2) and STEP (completion).
- HALT accepted during RUNNING: the instruction in the acceptance cycle executes; `cpu_en`=0 from the next cycle.
- STEP n with no breakpoint: `cpu_en` high for exactly n consecutive cycles. The response is valid the cycle after the last enabled cycle.
- Breakpoint: `cpu_en` drops in the same cycle `cpu_pc` matches. The instruction at `bp_addr` is not executed.
- `rsp_valid`/`rsp_data` stay stable while `rsp_valid` & !`rsp_ready`.
- While `rsp_valid` is held, RUNNING continues and commands stall.
- Reset asserted mid-operation: immediate return to reset values. A pending response is dropped, and a step in progress is abandoned.

## Structure
- Package `sr_debug_pkg` holds:
  - the `cmd_op_t` enum;
  - the `dbg_state_t` enum;
  - `DBG_REJECT` = 32'hFFFF_FFFF.
- No sub-module. The step counter, breakpoint comparator and one-entry response register are inline.
- `cpu_en` connects to the CPU as the enable of `r_pc` and an AND term on `regWrite`.

## Test plan
- Reset, then STEP 3 from PC 0: `cpu_en` high exactly 3 cycles; response 0x0000_000C; `instr_count`=3.
- READ x5 after `addi x5,x0,7` executes: response 0x0000_0007 two cycles after acceptance. READ x0 returns the current PC.
- SET_BP 0x10, then RUN: halts with `cpu_pc`=0x10 and `instr_count`=4. A further STEP 1 executes the instruction at 0x10, and its response is 0x14.
- RUN, then READ while RUNNING: response 0xFFFF_FFFF. Then HALT: response 0, and `halted`=1 on the next cycle.
- Hold `rsp_ready`=0 for 5 cycles after RUN: `rsp_data` stable, `cmd_ready`=0, CPU keeps executing. Illegal op 6 responds 0xFFFF_FFFF.
- Assert `rst` mid-STEP 100: `cpu_en`=0 immediately, `rsp_valid`=0, `instr_count`=0 and `halted`=1 after reset release.
